// File: rtl/manchester_pkg.sv
// Constants and the framer state encoding that the Manchester line stages share.
// The escape stage guarantees that START_WORD never appears inside a payload.
package manchester_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int PREAMBLE_LEN = 7;
    localparam int GAP_LEN      = 4;

    localparam logic [7:0] START_WORD      = 8'hD5;
    localparam logic [7:0] ESCAPE_SYMBOL   = 8'hE5;
    localparam logic [7:0] REPLACE_SYMBOL  = 8'hF5;
    localparam logic [7:0] PREAMBLE_SYMBOL = 8'h55;
    localparam logic [7:0] IDLE_SYMBOL     = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_GAP      = 2'd3
    } framer_state_t;

endpackage

// File: rtl/manchester_framer_if.sv
// Byte-wide AXI-Stream link between the Manchester line stages.
// A beat transfers on a rising edge where tvalid && tready; once tvalid is high the
// master holds tdata/tlast/tuser stable until that transfer, and tready may depend on tvalid.
interface manchester_framer_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/manchester_framer.sv
// Wraps each escaped packet as PREAMBLE_LEN preamble bytes, START_WORD, the payload,
// then GAP_LEN idle bytes, through a single output register.
module manchester_framer #(
    parameter int                    DATA_WIDTH      = manchester_pkg::DATA_WIDTH,
    parameter int                    PREAMBLE_LEN    = manchester_pkg::PREAMBLE_LEN,
    parameter int                    GAP_LEN         = manchester_pkg::GAP_LEN,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE_SYMBOL = manchester_pkg::PREAMBLE_SYMBOL,
    parameter logic [DATA_WIDTH-1:0] START_WORD      = manchester_pkg::START_WORD,
    parameter logic [DATA_WIDTH-1:0] IDLE_SYMBOL     = manchester_pkg::IDLE_SYMBOL
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    manchester_framer_if.slave            s_axis,
    manchester_framer_if.master           m_axis,
    output manchester_pkg::framer_state_t o_dbg_state,
    output logic [7:0]                    o_dbg_cnt
);

    localparam logic [7:0] PRE_LEN  = 8'(PREAMBLE_LEN);
    localparam logic [7:0] GAP_LAST = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);

    manchester_pkg::framer_state_t r_state;
    logic [7:0]                    r_cnt;
    logic [DATA_WIDTH-1:0]         r_tdata;
    logic                          r_tvalid;
    logic                          r_tlast;
    logic                          r_tuser;

    logic w_ld;
    logic w_s_ready;

    // The output register may take a new value when empty or being drained this cycle.
    assign w_ld      = !r_tvalid || m_axis.tready;
    assign w_s_ready = (r_state == manchester_pkg::ST_PAYLOAD) && w_ld;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= manchester_pkg::ST_IDLE;
            r_cnt    <= 8'd0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
        end else if (w_ld) begin
            unique case (r_state)
                manchester_pkg::ST_IDLE: begin
                    if (s_axis.tvalid) begin
                        r_tdata  <= PREAMBLE_SYMBOL;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b0;
                        r_tuser  <= 1'b1;
                        r_cnt    <= 8'd1;
                        r_state  <= manchester_pkg::ST_PREAMBLE;
                    end else begin
                        r_tvalid <= 1'b0;
                    end
                end
                manchester_pkg::ST_PREAMBLE: begin
                    r_tvalid <= 1'b1;
                    r_tlast  <= 1'b0;
                    r_tuser  <= 1'b1;
                    if (r_cnt < PRE_LEN) begin
                        r_tdata <= PREAMBLE_SYMBOL;
                        r_cnt   <= r_cnt + 8'd1;
                    end else begin
                        r_tdata <= START_WORD;
                        r_state <= manchester_pkg::ST_PAYLOAD;
                    end
                end
                manchester_pkg::ST_PAYLOAD: begin
                    // An upstream bubble is forwarded as an output bubble; framing is untouched.
                    if (s_axis.tvalid) begin
                        r_tdata  <= s_axis.tdata;
                        r_tvalid <= 1'b1;
                        r_tlast  <= s_axis.tlast;
                        r_tuser  <= 1'b0;
                        if (s_axis.tlast) begin
                            r_cnt   <= 8'd0;
                            r_state <= (GAP_LEN == 0) ? manchester_pkg::ST_IDLE
                                                      : manchester_pkg::ST_GAP;
                        end
                    end else begin
                        r_tvalid <= 1'b0;
                    end
                end
                manchester_pkg::ST_GAP: begin
                    r_tdata  <= IDLE_SYMBOL;
                    r_tvalid <= 1'b1;
                    r_tlast  <= 1'b0;
                    r_tuser  <= 1'b1;
                    r_cnt    <= r_cnt + 8'd1;
                    if (r_cnt == GAP_LAST) begin
                        r_state <= manchester_pkg::ST_IDLE;
                    end
                end
                default: begin
                    r_state <= manchester_pkg::ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis.tready = w_s_ready;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign m_axis.tuser  = r_tuser;

    assign o_dbg_state = r_state;
    assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_manchester_framer.sv
// Bench for manchester_framer: a default instance and a GAP_LEN=0 instance share one
// source/sink/monitor, selected by sel; expected beats come from a frame-level model.
module tb_manchester_framer;
  import manchester_pkg::*;

  localparam int PRE = 7;
  localparam int GAP = 4;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  manchester_framer_if #(.DW(8)) s_a ();
  manchester_framer_if #(.DW(8)) m_a ();
  manchester_framer_if #(.DW(8)) s_b ();
  manchester_framer_if #(.DW(8)) m_b ();

  framer_state_t st_a, st_b;
  logic [7:0]    cnt_a, cnt_b;

  manchester_framer u_dut_a (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axis      (s_a),
    .m_axis      (m_a),
    .o_dbg_state (st_a),
    .o_dbg_cnt   (cnt_a)
  );

  manchester_framer #(.GAP_LEN(0)) u_dut_b (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axis      (s_b),
    .m_axis      (m_b),
    .o_dbg_state (st_b),
    .o_dbg_cnt   (cnt_b)
  );

  logic       sel = 1'b0;
  logic       drv_valid = 1'b0;
  logic       drv_last = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       tb_ready = 1'b1;
  bit         rand_ready = 1'b0;

  assign s_a.tvalid = drv_valid & ~sel;
  assign s_a.tdata  = drv_data;
  assign s_a.tlast  = drv_last;
  assign s_a.tuser  = 1'b0;
  assign s_b.tvalid = drv_valid & sel;
  assign s_b.tdata  = drv_data;
  assign s_b.tlast  = drv_last;
  assign s_b.tuser  = 1'b0;
  assign m_a.tready = tb_ready;
  assign m_b.tready = tb_ready;

  wire       src_ready = sel ? s_b.tready : s_a.tready;
  wire       mon_valid = sel ? m_b.tvalid : m_a.tvalid;
  wire [7:0] mon_data  = sel ? m_b.tdata  : m_a.tdata;
  wire       mon_last  = sel ? m_b.tlast  : m_a.tlast;
  wire       mon_user  = sel ? m_b.tuser  : m_a.tuser;

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  logic [8:0] src_q[$];   // {tlast, tdata} presented upstream
  logic [9:0] exp_q[$];   // {tuser, tlast, tdata} expected downstream
  int exp_beats = 0;

  task automatic add_packet(input logic [7:0] bytes[$], input int gap);
    for (int p = 0; p < PRE; p++) exp_q.push_back({1'b1, 1'b0, 8'h55});
    exp_q.push_back({1'b1, 1'b0, 8'hD5});
    for (int i = 0; i < bytes.size(); i++) begin
      src_q.push_back({(i == bytes.size() - 1), bytes[i]});
      exp_q.push_back({1'b0, (i == bytes.size() - 1), bytes[i]});
    end
    for (int g = 0; g < gap; g++) exp_q.push_back({1'b1, 1'b0, 8'h00});
    exp_beats += PRE + 1 + bytes.size() + gap;
  endtask

  task automatic rand_packet(input int len, input int gap);
    logic [7:0] b[$];
    for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(0, 255)));
    add_packet(b, gap);
  endtask

  // ---------------- source driver ----------------
  int  bubble_cnt = 0;
  int  bub_at = -1;
  int  bub_len = 0;
  int  acc_cnt = 0;
  bit  started = 1'b0;
  int  start_cyc = 0;

  initial begin
    forever begin
      @(negedge aclk);
      if (bubble_cnt > 0) begin
        drv_valid = 1'b0;
        bubble_cnt--;
      end else if (src_q.size() > 0) begin
        drv_valid = 1'b1;
        {drv_last, drv_data} = src_q[0];
        if (!started) begin
          started = 1'b1;
          start_cyc = cyc;
        end
      end else begin
        drv_valid = 1'b0;
      end
      #1;
      if (drv_valid && src_ready) begin
        void'(src_q.pop_front());
        acc_cnt++;
        if (acc_cnt == bub_at) bubble_cnt = bub_len;
      end
    end
  end

  // ---------------- sink ----------------
  initial begin
    forever begin
      @(negedge aclk);
      tb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  int         beats = 0;
  int         user_beats = 0;
  int         holes = 0;
  int         idle_run = 0;
  int         first_cyc = 0;
  bit         held_ok = 1'b0;
  logic [10:0] held = '0;
  logic [9:0]  got = '0;

  initial begin
    forever begin
      @(negedge aclk);
      #2;
      if (held_ok) chk("hold_stable", {mon_valid, mon_user, mon_last, mon_data}, held);
      held_ok = 1'b0;
      if (mon_valid && tb_ready) begin
        got = {mon_user, mon_last, mon_data};
        if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
        else chk("beat", got, exp_q.pop_front());
        if (beats == 0) first_cyc = cyc;
        else holes += idle_run;
        idle_run = 0;
        beats++;
        if (mon_user) user_beats++;
      end else if (mon_valid) begin
        held = {mon_valid, mon_user, mon_last, mon_data};
        held_ok = 1'b1;
      end else if (beats > 0) begin
        idle_run++;
      end
    end
  end

  task automatic begin_test();
    beats = 0; user_beats = 0; holes = 0; idle_run = 0;
    started = 1'b0; acc_cnt = 0; bub_at = -1; bub_len = 0; exp_beats = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge aclk);
      #4;
      if (src_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    chk(tag, done, 1);
    src_q.delete();
    exp_q.delete();
    repeat (4) @(negedge aclk);
    #4;
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] pkt[$];

  initial begin
    repeat (3) @(negedge aclk);
    #4;
    chk("rst_tvalid", m_a.tvalid, 0);
    chk("rst_tdata", m_a.tdata, 0);
    chk("rst_tlast", m_a.tlast, 0);
    chk("rst_tuser", m_a.tuser, 0);
    chk("rst_sready", s_a.tready, 0);
    chk("rst_state", st_a, ST_IDLE);
    chk("rst_cnt", cnt_a, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    #4;
    chk("post_rst_sready", s_a.tready, 0);

    // Basic frame, ready held high
    begin_test();
    pkt = '{8'h01, 8'h02, 8'h03};
    add_packet(pkt, GAP);
    wait_done("t1_done", 200);
    chk("t1_beats", beats, 15);
    chk("t1_user_beats", user_beats, 12);
    chk("t1_latency", first_cyc - start_cyc, 1);
    chk("t1_holes", holes, 0);

    // Escape-like payload bytes pass unchanged
    begin_test();
    pkt = '{8'hE5, 8'hF5};
    add_packet(pkt, GAP);
    wait_done("t2_done", 200);
    chk("t2_beats", beats, exp_beats);

    // Random backpressure
    begin_test();
    rand_ready = 1'b1;
    for (int k = 0; k < 4; k++) rand_packet($urandom_range(1, 10), GAP);
    wait_done("t3_done", 2000);
    chk("t3_beats", beats, exp_beats);
    rand_ready = 1'b0;
    repeat (2) @(negedge aclk);
    #4;

    // Back-to-back frames with a gap
    begin_test();
    rand_packet($urandom_range(1, 6), GAP);
    rand_packet($urandom_range(1, 6), GAP);
    wait_done("t4_done", 300);
    chk("t4_beats", beats, exp_beats);
    chk("t4_holes", holes, 0);

    // Three-cycle upstream bubble mid-payload
    begin_test();
    bub_at = 3;
    bub_len = 3;
    rand_packet(8, GAP);
    wait_done("t5_done", 300);
    chk("t5_beats", beats, exp_beats);
    chk("t5_holes", holes, 3);
    chk("t5_user_beats", user_beats, 12);

    // Reset during preamble beat 4
    begin_test();
    rand_packet(5, GAP);
    for (int i = 0; i < 50 && beats < 4; i++) begin
      @(negedge aclk);
      #4;
    end
    chk("t6_reach_beat4", beats, 4);
    aresetn = 1'b0;
    src_q.delete();
    exp_q.delete();
    drv_valid = 1'b0;
    @(negedge aclk);
    #4;
    chk("t6_tvalid", m_a.tvalid, 0);
    chk("t6_tdata", m_a.tdata, 0);
    chk("t6_tlast", m_a.tlast, 0);
    chk("t6_tuser", m_a.tuser, 0);
    chk("t6_state", st_a, ST_IDLE);
    chk("t6_cnt", cnt_a, 0);
    chk("t6_sready", s_a.tready, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    #4;
    begin_test();
    rand_packet(4, GAP);
    wait_done("t6_done", 200);
    chk("t6_beats", beats, 16);
    chk("t6_user_beats", user_beats, 12);
    chk("t6_latency", first_cyc - start_cyc, 1);

    // GAP_LEN=0 instance: back-to-back with no empty cycle
    sel = 1'b1;
    @(negedge aclk);
    #4;
    begin_test();
    rand_packet($urandom_range(1, 6), 0);
    rand_packet($urandom_range(1, 6), 0);
    wait_done("t7_done", 300);
    chk("t7_beats", beats, exp_beats);
    chk("t7_holes", holes, 0);
    chk("t7_user_beats", user_beats, 16);
    chk("t7_latency", first_cyc - start_cyc, 1);

    // GAP_LEN=0 instance under random backpressure
    begin_test();
    rand_ready = 1'b1;
    for (int k = 0; k < 3; k++) rand_packet($urandom_range(1, 8), 0);
    wait_done("t8_done", 2000);
    chk("t8_beats", beats, exp_beats);
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
